// File: rtl/sequence_detector.sv
// Serial pattern detector: compares the last WIDTH accepted bits against a loaded pattern.
// Optional saturating match counter enabled by defining SEQUENCE_DETECTOR_COUNT_EN.
module sequence_detector #(
    parameter int WIDTH       = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [WIDTH-1:0]       pattern,
    input  logic                   overlap,
    input  logic                   en,
    input  logic                   a,
    output logic                   armed,
    output logic                   y,
    output logic [COUNT_WIDTH-1:0] match_count
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_MATCH  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   pattern_r;
    logic               overlap_r;
    logic [WIDTH-1:0]   history_r;
    logic [WIDTH-1:0]   history_next_s;
    logic [FILL_W-1:0]  fill_r;
    logic [FILL_W-1:0]  fill_next_s;
    logic [WIDTH-1:0]   h_shift_s;
    logic [FILL_W-1:0]  f_inc_s;
    logic               match_s;
    logic               y_r;
    logic               armed_r;

    // Candidate history/fill after accepting the current bit, and match test
    always_comb begin
        h_shift_s = {history_r[WIDTH-2:0], a};
        if (fill_r == FILL_FULL) begin
            f_inc_s = FILL_FULL;
        end else begin
            f_inc_s = fill_r + FILL_W'(1);
        end
        match_s = (f_inc_s == FILL_FULL) && (h_shift_s == pattern_r);
    end

    // Next-state logic; load overrides any stream activity
    always_comb begin
        state_next_s   = state_r;
        history_next_s = history_r;
        fill_next_s    = fill_r;
        if (load) begin
            state_next_s   = ST_SEARCH;
            history_next_s = {WIDTH{1'b0}};
            fill_next_s    = {FILL_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_SEARCH, ST_MATCH: begin
                    if (!en) begin
                        state_next_s = ST_SEARCH;
                    end else if (match_s) begin
                        state_next_s = ST_MATCH;
                        if (overlap_r) begin
                            history_next_s = h_shift_s;
                            fill_next_s    = FILL_FULL;
                        end else begin
                            history_next_s = {WIDTH{1'b0}};
                            fill_next_s    = {FILL_W{1'b0}};
                        end
                    end else begin
                        state_next_s   = ST_SEARCH;
                        history_next_s = h_shift_s;
                        fill_next_s    = f_inc_s;
                    end
                end
                default: begin
                    state_next_s   = ST_IDLE;
                    history_next_s = {WIDTH{1'b0}};
                    fill_next_s    = {FILL_W{1'b0}};
                end
            endcase
        end
    end

    // State, pattern and history registers; outputs registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pattern_r <= {WIDTH{1'b0}};
            overlap_r <= 1'b0;
            history_r <= {WIDTH{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            y_r       <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            history_r <= history_next_s;
            fill_r    <= fill_next_s;
            y_r       <= (state_next_s == ST_MATCH);
            armed_r   <= (state_next_s != ST_IDLE);
            if (load) begin
                pattern_r <= pattern;
                overlap_r <= overlap;
            end
        end
    end

    assign y     = y_r;
    assign armed = armed_r;

`ifdef SEQUENCE_DETECTOR_COUNT_EN
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    logic                   match_event_s;
    logic [COUNT_WIDTH-1:0] count_r;

    assign match_event_s = !load && (state_r != ST_IDLE) && en && match_s;

    // Saturating match counter, cleared by load
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end else if (load) begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end else if (match_event_s && (count_r != COUNT_MAX)) begin
            count_r <= count_r + COUNT_WIDTH'(1);
        end
    end

    assign match_count = count_r;
`else
    assign match_count = {COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Table-driven bench for sequence_detector (WIDTH=4, COUNT_WIDTH=2) plus hand-written corner sequences.
module tb_sequence_detector;

    localparam int WIDTH = 4;
    localparam int CW    = 2;

    logic             clock;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] pattern;
    logic             overlap;
    logic             en;
    logic             a;
    logic             armed;
    logic             y;
    logic [CW-1:0]    match_count;

    int checks = 0;
    int errors = 0;

    sequence_detector #(.WIDTH(WIDTH), .COUNT_WIDTH(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .pattern     (pattern),
        .overlap     (overlap),
        .en          (en),
        .a           (a),
        .armed       (armed),
        .y           (y),
        .match_count (match_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] pat;
        logic       ov;
        logic       e;
        logic       bit_a;
        logic       y_exp;
        logic       armed_exp;
        int         n_raw;
    } vec_t;

    vec_t vecs[$];

    // Counter value expected after n matches since last load/reset
    function automatic int exp_count(int n);
`ifdef SEQUENCE_DETECTOR_COUNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    task automatic add(logic r, logic ld, logic [3:0] p, logic ov, logic e, logic b,
                       logic ye, logic ae, int n);
        vec_t v;
        v.rst = r; v.ld = ld; v.pat = p; v.ov = ov; v.e = e; v.bit_a = b;
        v.y_exp = ye; v.armed_exp = ae; v.n_raw = n;
        vecs.push_back(v);
    endtask

    task automatic step(logic r, logic ld, logic [3:0] p, logic ov, logic e, logic b);
        reset = r; load = ld; pattern = p; overlap = ov; en = e; a = b;
        @(posedge clock);
        #1;
    endtask

    task automatic check(string nm, logic ye, logic ae, int n);
        logic [CW-1:0] ce;
        ce = CW'(exp_count(n));
        checks++;
        if (y !== ye || armed !== ae || match_count !== ce) begin
            errors++;
            $display("FAIL %s: got y=%0b armed=%0b count=%0d, expected y=%0b armed=%0b count=%0d",
                     nm, y, armed, match_count, ye, ae, ce);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; pattern = 4'b0000; overlap = 1'b0; en = 1'b0; a = 1'b0;

        // reset, then stream ignored while idle
        add(1'b1,1'b0,4'b0000,1'b0,1'b0,1'b0, 1'b0,1'b0,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b0,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b0,0);
        // basic match 0110, non-overlap
        add(1'b0,1'b1,4'b0110,1'b0,1'b0,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b1,1'b1,1);
        add(1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 1'b0,1'b1,1);
        // overlap=1 loaded; overlap input later driven 0 and must be ignored
        add(1'b0,1'b1,4'b1010,1'b1,1'b0,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b1,1'b1,1);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,1);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b1,1'b1,2);
        // overlap=0 loaded; overlap input later driven 1 and must be ignored
        add(1'b0,1'b1,4'b1010,1'b0,1'b0,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b1,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b1,1'b1,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b1,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b1,1'b1,1'b0, 1'b1,1'b1,1);
        add(1'b0,1'b0,4'b0000,1'b1,1'b1,1'b1, 1'b0,1'b1,1);
        add(1'b0,1'b0,4'b0000,1'b1,1'b1,1'b0, 1'b0,1'b1,1);
        // continuous strobe, 1111 overlap
        add(1'b0,1'b1,4'b1111,1'b1,1'b0,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b1,1'b1,1);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b1,1'b1,2);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b1,1'b1,3);
        add(1'b0,1'b0,4'b0000,1'b0,1'b0,1'b1, 1'b0,1'b1,3);
        // mid-stream reload restarts fill
        add(1'b0,1'b1,4'b0110,1'b0,1'b0,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b1,4'b0110,1'b0,1'b0,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b1,1'b1,1);
        // load together with en: bit dropped, so 1,1,0 gives only 3 valid bits
        add(1'b0,1'b1,4'b0110,1'b0,1'b1,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b1,0);
        // zero pattern needs four accepted bits; non-overlap restarts after match
        add(1'b0,1'b1,4'b0000,1'b0,1'b0,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b1,0);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b1,1'b1,1);
        add(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 1'b0,1'b1,1);
        // reset together with load: reset wins, stream then ignored
        add(1'b1,1'b1,4'b0110,1'b0,1'b1,1'b0, 1'b0,1'b0,0);
        add(1'b0,1'b0,4'b0110,1'b0,1'b1,1'b0, 1'b0,1'b0,0);
        add(1'b0,1'b0,4'b0110,1'b0,1'b1,1'b1, 1'b0,1'b0,0);
        add(1'b0,1'b0,4'b0110,1'b0,1'b1,1'b1, 1'b0,1'b0,0);
        add(1'b0,1'b0,4'b0110,1'b0,1'b1,1'b0, 1'b0,1'b0,0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].pat, vecs[i].ov, vecs[i].e, vecs[i].bit_a);
            check($sformatf("vec%0d", i), vecs[i].y_exp, vecs[i].armed_exp, vecs[i].n_raw);
        end

        // 1111 overlap with stall cycles between bits after the first match
        step(1'b0,1'b1,4'b1111,1'b1,1'b0,1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1);
            check($sformatf("ilv_fill%0d", i), 1'b0, 1'b1, 0);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1);
            check($sformatf("ilv_hit%0d", i), 1'b1, 1'b1, i);
            step(1'b0,1'b0,4'b0000,1'b0,1'b0,1'b1);
            check($sformatf("ilv_gap%0d", i), 1'b0, 1'b1, i);
        end

        // saturation: five non-overlapping 0110 matches with a 2-bit counter
        step(1'b0,1'b1,4'b0110,1'b0,1'b0,1'b0);
        for (int m = 1; m <= 5; m++) begin
            step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0);
            step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1);
            step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1);
            check($sformatf("sat_pre%0d", m), 1'b0, 1'b1, m - 1);
            step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0);
            check($sformatf("sat_hit%0d", m), 1'b1, 1'b1, m);
        end

        // reset mid-stream, then the completing bit is ignored
        step(1'b0,1'b1,4'b0110,1'b0,1'b0,1'b0);
        step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0);
        step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1);
        step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b1);
        step(1'b1,1'b0,4'b0000,1'b0,1'b1,1'b0);
        check("rst_mid", 1'b0, 1'b0, 0);
        step(1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0);
        check("rst_ignored", 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_detector.md
# sequence_detector

Parametrised serial pattern detector, the next generation of the team's fixed two-bit "01" Moore detector. It samples a one-bit stream under an enable and compares the last WIDTH accepted bits against a runtime-loaded pattern. It supports overlapping and non-overlapping match modes, signals each match with a registered single-cycle Moore pulse, and optionally keeps a saturating match counter. It sits between a serial bit source and control logic that needs a match strobe.

## Interface
- WIDTH, 4, pattern length in bits; legal range 2..16
- COUNT_WIDTH, 8, width of match counter; legal range 1..32
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  capture pattern and overlap, clear history, enter SEARCH
- pattern  input  WIDTH  pattern to detect; MSB is the oldest bit
- overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping
- en  input  1  bit-valid; a is accepted on edges where en=1
- a  input  1  serial data bit
- armed  output  1  high in SEARCH or MATCH, meaning a pattern is loaded
- y  output  1  match strobe; high exactly in MATCH state
- match_count  output  COUNT_WIDTH  saturating number of matches since last load or reset

## Operation
- Internal registers:
  - state: IDLE, SEARCH or MATCH
  - pattern_reg (WIDTH bits) and overlap_reg
  - history (WIDTH bits)
  - fill (0..WIDTH): count of valid history bits
  - count
- Reset (sync, highest priority):
  - state=IDLE, with pattern_reg, overlap_reg, history, fill and count all 0
  - Outputs: y=0, armed=0, match_count=0
- load=1 (priority over en):
  - pattern_reg<=pattern, overlap_reg<=overlap
  - history<=0, fill<=0, count<=0, state<=SEARCH
  - a is ignored that cycle
  - Legal from any state, including mid-stream.
- IDLE: en and a are ignored; state stays IDLE until load.
- SEARCH or MATCH with en=1:
  - h_next = {history[WIDTH-2:0], a}
  - f_next = min(fill+1, WIDTH)
  - Match if f_next==WIDTH and h_next==pattern_reg. A match can never occur before WIDTH bits have been accepted, so an all-zero pattern does not fire on reset history.
  - On match: state<=MATCH, and count increments, saturating at 2^COUNT_WIDTH-1.
    - If overlap_reg=1: history<=h_next, fill<=WIDTH.
    - If overlap_reg=0: history<=0, fill<=0.
  - No match: state<=SEARCH, history<=h_next, fill<=f_next.
- SEARCH or MATCH with en=0: history and fill hold; state<=SEARCH.
- Output decoding:
  - y = (state==MATCH)
  - armed = (state!=IDLE)
  - match_count = count
- overlap is sampled only on load; changing it later has no effect.

## Timing
- Latency: a matching bit accepted at edge k drives y=1 during the cycle after edge k. match_count shows the new value in that same cycle.
- y is one cycle per match. Back-to-back matches on consecutive accepted bits keep y high continuously, e.g. all-ones pattern with overlap.
- Stall: en=0 in the cycle after a match returns y to 0 at the next edge.
- Simultaneous events:
  - reset+load: reset wins.
  - load+en: load wins and the bit is dropped.
- Saturation: the counter holds at its maximum; y still pulses on further matches.

## Configuration
- Macro: SEQUENCE_DETECTOR_COUNT_EN.
- Defined: the match counter is implemented as described.
- Undefined:
  - No counter register is built and match_count is tied to 0.
  - All other behaviour, including y timing, is identical.

## Test plan
- Basic match:
  - Stimulus: reset, then load pattern=4'b0110 with overlap=0, then bits 0,1,1,0 with en=1.
  - Response: y=1 for one cycle after the 4th bit; match_count=1; armed=1 after load.
- Overlap versus non-overlap:
  - Stimulus: pattern=4'b1010, stream 1,0,1,0,1,0.
  - With overlap=1: y after bits 4 and 6, final count=2.
  - With overlap=0: y after bit 4 only, final count=1.
- Continuous strobe:
  - Stimulus: pattern=4'b1111, overlap=1, six consecutive 1s.
  - Response: y high 3 consecutive cycles, after bits 4, 5 and 6; count=3.
  - Stimulus: same stream with en=0 cycles interleaved.
  - Response: y pulses are separated and count=3.
- Saturation:
  - Stimulus: COUNT_WIDTH=2, 5 non-overlapping matches of 4'b0110.
  - Response: match_count reads 1,2,3,3,3; y pulses 5 times.
  - With SEQUENCE_DETECTOR_COUNT_EN undefined: match_count stays 0 and y is unchanged.
- Mid-stream load and reset:
  - Stimulus: load 4'b0110, send 0,1,1, then load again, then send 0.
  - Response: no y; fill restarts from 0.
  - Stimulus: reset mid-stream.
  - Response: armed=0, y=0, match_count=0, and the stream is ignored until the next load.
- Zero pattern:
  - Stimulus: load 4'b0000, then 3 zeros.
  - Response: no y.
  - Stimulus: a 4th zero.
  - Response: y=1 and count=1.
